// File: rtl/activation_skew_feeder.sv
// Left-edge activation feeder for the systolic grid: vector FIFO, diagonal skew, tile flush.
// Optional SKEW_FEEDER_PERF_EN adds a saturating stall_count output.
module activation_skew_feeder #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*DATA_WIDTH-1:0]   in_data,
  input  logic                      in_last,
  output logic [N*DATA_WIDTH-1:0]   out_data,
  output logic                      grid_enable,
  output logic                      tile_done,
`ifdef SKEW_FEEDER_PERF_EN
  output logic                      busy,
  output logic [31:0]               stall_count
`else
  output logic                      busy
`endif
);

  localparam int W  = N * DATA_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(2 * N);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t          state, next_state;
  logic [W:0]      mem [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]   drain_cnt;
  logic            fifo_full, fifo_empty;
  logic            push, pop, adv;
  logic [W:0]      head;
  logic [W-1:0]    feed;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign pop        = (state == STREAM) && !fifo_empty;
  assign adv        = pop || (state == DRAIN);
  assign feed       = (state == STREAM) ? head[W-1:0] : '0;
  assign tile_done  = (state == DONE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_last, in_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      state       <= IDLE;
      drain_cnt   <= '0;
      grid_enable <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      state       <= next_state;
      grid_enable <= adv;
      if (pop && head[W])
        drain_cnt <= CW'(2 * N - 1);
      else if (state == DRAIN)
        drain_cnt <= drain_cnt - 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!fifo_empty) next_state = STREAM;
      STREAM:  if (pop && head[W]) next_state = DRAIN;
      DRAIN:   if (drain_cnt == CW'(1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Lane g is a (g+1)-deep shift chain; its tail drives grid row g.
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic [(g+1)*DATA_WIDTH-1:0] sr;
    if (g == 0) begin : g_head
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)   sr <= '0;
        else if (adv) sr <= feed[DATA_WIDTH-1:0];
      end
    end else begin : g_chain
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)   sr <= '0;
        else if (adv) sr <= {sr[g*DATA_WIDTH-1:0], feed[g*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
    assign out_data[g*DATA_WIDTH +: DATA_WIDTH] = sr[(g+1)*DATA_WIDTH-1 -: DATA_WIDTH];
  end

`ifdef SKEW_FEEDER_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_count <= '0;
    else if (next_state == DONE && state != DONE)
      stall_count <= '0;
    else if (state == STREAM && fifo_empty && stall_count != '1)
      stall_count <= stall_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_activation_skew_feeder.sv
// Self-checking bench for activation_skew_feeder: directed tile table, full/reset sequences,
// and random tiles compared against an index-based skew model.
module tb_activation_skew_feeder;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int W  = N * DW;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, in_last, grid_enable, tile_done, busy;
  logic [W-1:0] in_data, out_data;
`ifdef SKEW_FEEDER_PERF_EN
  logic [31:0]  stall_count;
`endif

  always #5 clk = ~clk;

  activation_skew_feeder #(.N(N), .DATA_WIDTH(DW), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_data(out_data),
    .grid_enable(grid_enable), .tile_done(tile_done),
`ifdef SKEW_FEEDER_PERF_EN
    .busy(busy), .stall_count(stall_count)
`else
    .busy(busy)
`endif
  );

  typedef struct {
    int           nvec;
    logic [W-1:0] v0;
    logic [W-1:0] v1;
    int           gap;
    int           exp_enables;
    int           exp_stall;
  } vec_t;

  int           vectors = 0, miscompares = 0;
  int           done_cnt = 0;
  logic [W-1:0] cap[$];
  logic [W-1:0] expq[$];
  logic [W-1:0] prev_out = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // One clock: sample just after the edge, record enabled outputs, check freeze otherwise.
  task automatic tick();
    @(posedge clk);
    #1;
    if (grid_enable) cap.push_back(out_data);
    else if (reset)  check("freeze", out_data, prev_out);
    prev_out = out_data;
    if (tile_done) done_cnt++;
  endtask

  // Enabled cycle t shows, on lane i, element i of vector t-i (zero outside the tile).
  function automatic void model(input logic [W-1:0] v[$]);
    int k = v.size();
    for (int t = 0; t < k + 2*N - 1; t++) begin
      logic [W-1:0] e = '0;
      for (int i = 0; i < N; i++) begin
        int idx = t - i;
        if (idx >= 0 && idx < k) e[i*DW +: DW] = v[idx][i*DW +: DW];
      end
      expq.push_back(e);
    end
  endfunction

  task automatic push_vec(input logic [W-1:0] d, input logic last);
    bit acc = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    for (int c = 0; c < 200 && !acc; c++) begin
      acc = in_ready;
      tick();
    end
    if (!acc) check("push_timeout", 0, 1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input int tiles);
    for (int c = 0; c < 500 && done_cnt < tiles; c++) tick();
    check("tile_done_count", done_cnt, tiles);
    tick();
    check("busy_after_done", busy, 0);
    check("enable_after_done", grid_enable, 0);
  endtask

  task automatic compare_cap(input string name);
    int n;
    check({name, "_enable_count"}, cap.size(), expq.size());
    n = (cap.size() < expq.size()) ? cap.size() : expq.size();
    for (int i = 0; i < n; i++) check({name, "_lanes"}, cap[i], expq[i]);
  endtask

  task automatic run_tile(input logic [W-1:0] v[$], input int gap, input int exp_stall);
    int k = v.size();
    cap.delete(); expq.delete(); done_cnt = 0;
    model(v);
    for (int j = 0; j < k; j++) begin
      push_vec(v[j], j == k - 1);
`ifdef SKEW_FEEDER_PERF_EN
      if (j == 1 && exp_stall >= 0) check("stall_count", stall_count, exp_stall);
`endif
      if (j < k - 1) repeat (gap) tick();
    end
    wait_done(1);
    compare_cap("tile");
`ifdef SKEW_FEEDER_PERF_EN
    check("stall_cleared", stall_count, 0);
`endif
  endtask

  initial begin
    vec_t         tbl[4];
    logic [W-1:0] v[$];
    logic [W-1:0] t2[$];
    logic [W-1:0] t1[$];

    // A gap of 4 idle input cycles leaves the FIFO empty for 3 STREAM cycles.
    tbl[0] = '{2, 32'h04030201, 32'h08070605, 0, 9, -1};
    tbl[1] = '{1, 32'h09090909, 32'h0,        0, 8, -1};
    tbl[2] = '{2, 32'h04030201, 32'h08070605, 4, 9,  3};
    tbl[3] = '{2, 32'hA1B2C3D4, 32'h5E6F7081, 1, 9, -1};

    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    repeat (2) tick();
    check("rst_out_data", out_data, 0);
    check("rst_enable", grid_enable, 0);
    check("rst_tile_done", tile_done, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b1;
    tick();

    for (int e = 0; e < 4; e++) begin
      v.delete();
      v.push_back(tbl[e].v0);
      if (tbl[e].nvec > 1) v.push_back(tbl[e].v1);
      run_tile(v, tbl[e].gap, tbl[e].exp_stall);
      check("table_enables", cap.size(), tbl[e].exp_enables);
      if (e == 0 && cap.size() >= 5) begin
        check("skew_lane0_t0", cap[0][7:0], 8'd1);
        check("skew_lane0_t1", cap[1][7:0], 8'd5);
        check("skew_lane1_t2", cap[2][15:8], 8'd6);
        check("skew_lane3_t3", cap[3][31:24], 8'd4);
        check("skew_lane3_t4", cap[4][31:24], 8'd8);
      end
    end

    // Continuous pushes keep occupancy at 2 while popping every cycle.
    v.delete();
    for (int j = 0; j < 6; j++) v.push_back(W'(32'h10101010 * (j + 1)));
    run_tile(v, 0, -1);

    // Fill the FIFO while the previous tile is draining.
    cap.delete(); expq.delete(); done_cnt = 0;
    t1.delete(); t2.delete();
    t1.push_back(32'h11223344);
    for (int j = 0; j < 4; j++) t2.push_back($urandom);
    model(t1); model(t2);
    push_vec(t1[0], 1'b1);
    for (int j = 0; j < 4; j++) push_vec(t2[j], j == 3);
    check("full_in_ready", in_ready, 0);
    in_valid = 1'b1; in_data = 32'hDEADBEEF; in_last = 1'b1;
    repeat (2) begin
      tick();
      check("full_held_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    wait_done(2);
    compare_cap("full");

    // Asynchronous reset in the middle of streaming.
    push_vec(32'hAAAAAAAA, 1'b0);
    push_vec(32'hBBBBBBBB, 1'b0);
    push_vec(32'hCCCCCCCC, 1'b0);
    reset = 1'b0;
    #1;
    check("midrst_out_data", out_data, 0);
    check("midrst_enable", grid_enable, 0);
    check("midrst_tile_done", tile_done, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) begin
      tick();
      check("post_rst_busy", busy, 0);
      check("post_rst_enable", grid_enable, 0);
    end
    v.delete();
    v.push_back(32'h0D0C0B0A);
    run_tile(v, 0, -1);

    for (int r = 0; r < 20; r++) begin
      int k = $urandom_range(6, 1);
      v.delete();
      for (int j = 0; j < k; j++) v.push_back($urandom);
      run_tile(v, $urandom_range(2, 0), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
